// File: rtl/dmem_if.sv
// Data-memory bus between the datapath (master) and the data-memory/MMIO stage (slave).
// ReadData is combinational from Addr in the same cycle.
interface dmem_if;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, Addr, WriteData, input ReadData);
  modport slave  (input MemWrite, Addr, WriteData, output ReadData);
endinterface

// File: rtl/dmem_mmio.sv
// Data memory stage: word-addressed RAM plus MMIO (LEDs, synchronized switches,
// and a 32-bit compare timer with a sticky match flag and interrupt).
module dmem_mmio #(
  parameter int RAM_WORDS = 64,
  parameter int LED_W     = 10,
  parameter int SW_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  dmem_if.slave            bus,
  input  logic [SW_W-1:0]  Switches,
  output logic [LED_W-1:0] Leds,
  output logic             TimerIrq
);
  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]      r_ram [RAM_WORDS];
  logic [LED_W-1:0] r_leds;
  logic [SW_W-1:0]  r_sw_s1, r_sw_s2;
  logic [31:0]      r_tcount, r_tcmp;
  logic             r_en, r_ar, r_ie, r_match;

  logic          w_io_sel, w_ram_sel, w_wr_io, w_hit;
  logic          w_wr_led, w_wr_tcount, w_wr_tcmp, w_wr_tctrl;
  logic [8:0]    w_word;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  // Byte-lane bits are dropped: misaligned accesses hit the containing word.
  assign w_unused    = ^bus.Addr[1:0];
  assign w_io_sel    = (bus.Addr[31:11] == '0);
  assign w_ram_sel   = (bus.Addr[31:AW+2] == '0);
  assign w_word      = bus.Addr[10:2];
  assign w_idx       = bus.Addr[AW+1:2];
  assign w_wr_io     = bus.MemWrite & w_io_sel;
  assign w_wr_led    = w_wr_io & (w_word == 9'h100);
  assign w_wr_tcount = w_wr_io & (w_word == 9'h102);
  assign w_wr_tcmp   = w_wr_io & (w_word == 9'h103);
  assign w_wr_tctrl  = w_wr_io & (w_word == 9'h104);
  assign w_hit       = r_en & (r_tcount == r_tcmp);

  assign Leds     = r_leds;
  assign TimerIrq = r_match & r_ie;

  // RAM has no reset, so a store in the reset cycle still lands.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && w_ram_sel) r_ram[w_idx] <= bus.WriteData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds   <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_tcount <= '0;
      r_tcmp   <= 32'hFFFF_FFFF;
      r_en     <= 1'b0;
      r_ar     <= 1'b0;
      r_ie     <= 1'b0;
      r_match  <= 1'b0;
    end else begin
      r_sw_s1 <= Switches;
      r_sw_s2 <= r_sw_s1;
      if (w_wr_led)  r_leds <= bus.WriteData[LED_W-1:0];
      if (w_wr_tcmp) r_tcmp <= bus.WriteData;
      if (w_wr_tctrl) begin
        r_en <= bus.WriteData[0];
        r_ar <= bus.WriteData[1];
        r_ie <= bus.WriteData[3];
        if (bus.WriteData[2]) r_match <= 1'b0;
      end
      // Later assignments win: a hardware match overrides W1C and a written EN.
      if (w_wr_tcount) begin
        r_tcount <= bus.WriteData;
      end else if (w_hit) begin
        r_match <= 1'b1;
        if (r_ar) r_tcount <= '0;
        else      r_en     <= 1'b0;
      end else if (r_en) begin
        r_tcount <= r_tcount + 32'd1;
      end
    end
  end

  always_comb begin
    bus.ReadData = '0;
    if (w_ram_sel) begin
      bus.ReadData = r_ram[w_idx];
    end else if (w_io_sel) begin
      case (w_word)
        9'h100:  bus.ReadData = 32'(r_leds);
        9'h101:  bus.ReadData = 32'(r_sw_s2);
        9'h102:  bus.ReadData = r_tcount;
        9'h103:  bus.ReadData = r_tcmp;
        9'h104:  bus.ReadData = 32'({r_ie, r_match, r_ar, r_en});
        default: bus.ReadData = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus a randomized run
// compared against an address-map level reference model.
module tb_dmem_mmio;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] sw;
  logic [9:0] leds;
  logic       irq;
  int checks = 0;
  int failures = 0;

  dmem_if bus();

  dmem_mmio #(.RAM_WORDS(64), .LED_W(10), .SW_W(10)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .Switches(sw), .Leds(leds), .TimerIrq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_ram [64];
  bit          m_ramv [64];
  logic [9:0]  m_leds;
  logic [9:0]  sw_q[$];
  logic [31:0] m_cnt, m_cmp;
  bit          m_en, m_ar, m_ie, m_match;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (a[31:11] != 0) return 32'h0;
    if (w < 32'h100) return m_ram[w[7:2]];
    case (w)
      32'h400: return {22'h0, m_leds};
      32'h404: return {22'h0, sw_q[0]};
      32'h408: return m_cnt;
      32'h40C: return m_cmp;
      32'h410: return {28'h0, m_ie, m_match, m_ar, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic rst, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [9:0] s);
    logic [31:0] w;
    bit hit, ar0, en0;
    w   = {a[31:2], 2'b00};
    hit = m_en && (m_cnt == m_cmp);
    ar0 = m_ar;
    en0 = m_en;
    if (we && w < 32'h100) begin
      m_ram[w[7:2]]  = d;
      m_ramv[w[7:2]] = 1'b1;
    end
    if (rst) begin
      m_leds = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
      m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
      sw_q.delete(); sw_q.push_back(10'd0); sw_q.push_back(10'd0);
      return;
    end
    void'(sw_q.pop_front());
    sw_q.push_back(s);
    if (we && w == 32'h400) m_leds = d[9:0];
    if (we && w == 32'h40C) m_cmp = d;
    if (we && w == 32'h410) begin
      m_en = d[0]; m_ar = d[1]; m_ie = d[3];
      if (d[2]) m_match = 0;
    end
    if (we && w == 32'h408) m_cnt = d;
    else if (hit) begin
      m_match = 1;
      if (ar0) m_cnt = 0;
      else     m_en = 0;
    end else if (en0) m_cnt = m_cnt + 1;
  endtask

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = we;
    bus.Addr      = a;
    bus.WriteData = d;
    @(posedge clk);
    model_edge(reset, we, a, d, sw);
    #1;
    bus.MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [5] = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410};
    logic [31:0] exps  [5] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    reset = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    reset = 1'b0;
    foreach (addrs[i]) begin
      bus.Addr = addrs[i]; #1;
      checks++;
      if (bus.ReadData !== exps[i]) begin
        failures++;
        $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[i], bus.ReadData, exps[i]);
      end
    end
    checks++;
    if (leds !== 10'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs leds=%h irq=%b exp leds=0 irq=0", leds, irq);
    end
  endtask

  task automatic test_ram();
    logic [31:0] addrs [5] = '{32'h10, 32'h13, 32'h14, 32'h18, 32'h00};
    logic [31:0] exps  [5] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 32'h0000A5A5, 32'h11111111};
    step(1, 32'h00, 32'h11111111);
    step(1, 32'h10, 32'hDEADBEEF);
    step(1, 32'h14, 32'h12345678);
    step(1, 32'h1B, 32'h0000A5A5);
    foreach (addrs[i]) begin
      bus.Addr = addrs[i]; #1;
      checks++;
      if (bus.ReadData !== exps[i]) begin
        failures++;
        $display("FAIL ram_read addr=%h got=%h exp=%h", addrs[i], bus.ReadData, exps[i]);
      end
    end
  endtask

  task automatic test_decode();
    logic [31:0] addrs [5] = '{32'h400, 32'h800, 32'h000, 32'h404, 32'h104};
    logic [31:0] exps  [5] = '{32'h3FF, 32'h0, 32'h11111111, 32'h0, 32'h0};
    step(1, 32'h400, 32'hFFFF_FFFF);
    checks++;
    if (leds !== 10'h3FF) begin
      failures++;
      $display("FAIL led_out got=%h exp=3ff", leds);
    end
    step(1, 32'h800, 32'h5);
    step(1, 32'h404, 32'hFFFF_FFFF);
    step(1, 32'h104, 32'h77);
    foreach (addrs[i]) begin
      bus.Addr = addrs[i]; #1;
      checks++;
      if (bus.ReadData !== exps[i]) begin
        failures++;
        $display("FAIL decode_read addr=%h got=%h exp=%h", addrs[i], bus.ReadData, exps[i]);
      end
    end
  endtask

  task automatic test_switch_sync();
    sw = 10'h2A1;
    step(0, 32'h404, 0);
    bus.Addr = 32'h404; #1;
    checks++;
    if (bus.ReadData !== 32'h0) begin
      failures++;
      $display("FAIL sw_sync_edge1 got=%h exp=0", bus.ReadData);
    end
    step(0, 32'h404, 0);
    bus.Addr = 32'h404; #1;
    checks++;
    if (bus.ReadData !== 32'h2A1 || bus.ReadData !== m_read(32'h404)) begin
      failures++;
      $display("FAIL sw_sync_edge2 got=%h exp=2a1", bus.ReadData);
    end
  endtask

  task automatic test_oneshot();
    step(1, 32'h40C, 5);
    step(1, 32'h408, 0);
    step(1, 32'h410, 32'h9);
    repeat (5) step(0, 0, 0);
    bus.Addr = 32'h408; #1;
    checks++;
    if (bus.ReadData !== 32'd5) begin
      failures++;
      $display("FAIL oneshot_count got=%h exp=5", bus.ReadData);
    end
    step(0, 0, 0);
    bus.Addr = 32'h410; #1;
    checks++;
    if (bus.ReadData !== 32'hC || irq !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_match tctrl=%h irq=%b exp tctrl=c irq=1", bus.ReadData, irq);
    end
    step(0, 0, 0);
    bus.Addr = 32'h408; #1;
    checks++;
    if (bus.ReadData !== 32'd5) begin
      failures++;
      $display("FAIL oneshot_hold got=%h exp=5", bus.ReadData);
    end
    step(1, 32'h410, 32'h4);
    bus.Addr = 32'h410; #1;
    checks++;
    if (bus.ReadData !== 32'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_clear tctrl=%h irq=%b exp tctrl=0 irq=0", bus.ReadData, irq);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] seq  [6] = '{0, 1, 2, 0, 1, 2};
    logic [31:0] ctrl [6] = '{3, 3, 3, 7, 7, 7};
    step(1, 32'h40C, 2);
    step(1, 32'h408, 0);
    step(1, 32'h410, 32'h3);
    for (int i = 0; i < 6; i++) begin
      bus.Addr = 32'h408; #1;
      checks++;
      if (bus.ReadData !== seq[i]) begin
        failures++;
        $display("FAIL reload_seq i=%0d got=%h exp=%h", i, bus.ReadData, seq[i]);
      end
      bus.Addr = 32'h410; #1;
      checks++;
      if (bus.ReadData !== ctrl[i]) begin
        failures++;
        $display("FAIL reload_ctrl i=%0d got=%h exp=%h", i, bus.ReadData, ctrl[i]);
      end
      if (i == 5) step(1, 32'h410, 32'h7);
      else        step(0, 0, 0);
    end
    bus.Addr = 32'h410; #1;
    checks++;
    if (bus.ReadData !== 32'h7 || irq !== 1'b0) begin
      failures++;
      $display("FAIL collision_set_wins tctrl=%h irq=%b exp tctrl=7 irq=0", bus.ReadData, irq);
    end
    step(0, 0, 0);
    step(1, 32'h408, 32'h100);
    bus.Addr = 32'h408; #1;
    checks++;
    if (bus.ReadData !== 32'h100) begin
      failures++;
      $display("FAIL tcount_override got=%h exp=100", bus.ReadData);
    end
    step(1, 32'h410, 32'h4);
  endtask

  task automatic test_wrap_reset();
    logic [31:0] seq [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] addrs [4] = '{32'h408, 32'h40C, 32'h410, 32'h20};
    logic [31:0] exps  [4] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'hCAFEF00D};
    step(1, 32'h40C, 0);
    step(1, 32'h408, 32'hFFFF_FFFE);
    step(1, 32'h410, 32'h1);
    for (int i = 0; i < 3; i++) begin
      bus.Addr = 32'h408; #1;
      checks++;
      if (bus.ReadData !== seq[i]) begin
        failures++;
        $display("FAIL wrap_seq i=%0d got=%h exp=%h", i, bus.ReadData, seq[i]);
      end
      step(0, 0, 0);
    end
    bus.Addr = 32'h410; #1;
    checks++;
    if (bus.ReadData !== 32'h4) begin
      failures++;
      $display("FAIL wrap_match tctrl=%h exp=4", bus.ReadData);
    end
    step(1, 32'h408, 0);
    step(1, 32'h410, 32'hB);
    step(1, 32'h400, 32'h155);
    step(0, 0, 0);
    checks++;
    if (irq !== 1'b1 || leds !== 10'h155) begin
      failures++;
      $display("FAIL pre_reset irq=%b leds=%h exp irq=1 leds=155", irq, leds);
    end
    reset = 1'b1;
    step(1, 32'h20, 32'hCAFEF00D);
    reset = 1'b0;
    foreach (addrs[i]) begin
      bus.Addr = addrs[i]; #1;
      checks++;
      if (bus.ReadData !== exps[i]) begin
        failures++;
        $display("FAIL midreset_read addr=%h got=%h exp=%h", addrs[i], bus.ReadData, exps[i]);
      end
    end
    checks++;
    if (leds !== 10'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs leds=%h irq=%b exp leds=0 irq=0", leds, irq);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, ra, e;
    logic        we;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1: ra = $urandom_range(0, 32'hFF);
        2:    ra = $urandom;
        3:    ra = $urandom_range(0, 32'h7FF);
        default: ra = 32'h400 + 4 * $urandom_range(0, 4) + $urandom_range(0, 3);
      endcase
      bus.Addr = ra; #1;
      e = m_read(ra);
      if (!(ra[31:11] == 0 && ra < 32'h100 && !m_ramv[ra[7:2]])) begin
        checks++;
        if (bus.ReadData !== e) begin
          failures++;
          $display("FAIL rand_read n=%0d addr=%h got=%h exp=%h", n, ra, bus.ReadData, e);
        end
      end
      checks++;
      if (leds !== m_leds || irq !== (m_match & m_ie)) begin
        failures++;
        $display("FAIL rand_outputs n=%0d leds=%h irq=%b exp leds=%h irq=%b",
                 n, leds, irq, m_leds, m_match & m_ie);
      end
      if ($urandom_range(0, 7) == 0) sw = 10'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      we = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0, 1: begin a = $urandom_range(0, 32'hFF); d = $urandom; end
        2:    begin a = 32'h408; d = $urandom_range(0, 12); end
        3:    begin a = 32'h40C; d = $urandom_range(0, 12); end
        4, 5: begin a = 32'h410; d = $urandom_range(0, 15); end
        6:    begin a = 32'h400; d = $urandom; end
        default: begin a = $urandom; d = $urandom; end
      endcase
      step(we, a, d);
      reset = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0;
    sw = 10'h0;
    bus.MemWrite = 1'b0;
    bus.Addr = 32'h0;
    bus.WriteData = 32'h0;
    sw_q.push_back(10'd0);
    sw_q.push_back(10'd0);
    foreach (m_ramv[i]) m_ramv[i] = 1'b0;
    #1;
    test_reset();
    test_ram();
    test_decode();
    test_switch_sync();
    test_oneshot();
    test_autoreload();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-memory stage directly downstream of the single-cycle datapath.
- Consumes the ALU result as the address and the shifted store operand as the write data, and returns read data to the result mux in the same cycle.
- Decodes a word-addressed RAM plus a memory-mapped I/O region: LED register, synchronized switches, and a 32-bit compare timer with a sticky match flag and interrupt line.
- Target is the FPGA board build of the processor.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; must be a power of 2, ≤ 256.
- LED_W, 10, width of LED output register.
- SW_W, 10, width of switch input.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  store strobe for the current instruction.
- Addr  in  32  byte address (ALUResult); bits [1:0] ignored.
- WriteData  in  32  store data.
- ReadData  out  32  load data, combinational from Addr and current state.
- Switches  in  SW_W  asynchronous board switches.
- Leds  out  LED_W  LED register contents.
- TimerIrq  out  1  match flag AND irq-enable bit.

Behaviour:
- Address map, word aligned, Addr[1:0] ignored; a misaligned access acts on the containing word.
  - 0x000–(4·RAM_WORDS−1): RAM, index Addr[log2(RAM_WORDS)+1:2].
  - 0x400: LED register, RW; write takes WriteData[LED_W-1:0]; read zero-extends.
  - 0x404: SWITCH register, RO; zero-extended synchronized switches; writes ignored.
  - 0x408: TCOUNT, RW.
  - 0x40C: TCMP, RW.
  - 0x410: TCTRL, RW. Bit0 EN, bit1 AUTORELOAD, bit3 IE, bit2 MATCH (read: flag; write 1 clears; write 0 no effect). Other bits read 0.
  - Any other address, including Addr[31:11] ≠ 0: reads 0, writes ignored.
- Reads: purely combinational, zero added latency; value reflects state before the current edge.
- Writes: take effect at the rising edge when MemWrite=1; visible to a read in the following cycle.
- RAM: contents not reset; read of an unwritten word is X in simulation.
- Switches: 2-flop synchronizer. A Switches change is visible on ReadData exactly 2 edges later. Sync flops reset to 0.
- Timer, per edge, in priority order:
  1. reset: TCOUNT=0, TCMP=0xFFFF_FFFF, EN=0, AUTORELOAD=0, IE=0, MATCH=0.
  2. CPU write to TCOUNT loads WriteData and suppresses increment and match evaluation that cycle.
  3. Else, if EN=1 and TCOUNT==TCMP: set MATCH. If AUTORELOAD=1, TCOUNT←0 and EN stays 1; else TCOUNT holds and EN←0.
  4. Else, if EN=1: TCOUNT←TCOUNT+1, wrapping 0xFFFF_FFFF→0.
- TCMP write: takes effect next edge; a match is evaluated against the old TCMP in the write cycle.
- TCTRL write: updates EN/AUTORELOAD/IE from WriteData. MATCH is cleared only if WriteData[2]=1.
- Simultaneous hardware MATCH set and W1C clear in the same cycle: set wins, MATCH=1.
- Simultaneous EN←0 by a TCTRL write and auto-stop on match: EN=0, MATCH=1.
- TimerIrq: registered-state function MATCH&IE, no extra delay; 0 from reset.
- Leds reset to 0.
- Reset asserted mid-count or mid-store: all registers take reset values at that edge. A RAM write presented in the reset cycle is still performed.

Test Plan:
- RAM store/load: write 0xDEADBEEF to 0x10, then 0x12345678 to 0x14. Read 0x10 → 0xDEADBEEF, read 0x13 → 0xDEADBEEF, read 0x14 → 0x12345678.
- MMIO/decode:
  - Write 0xFFFF_FFFF to 0x400 → Leds=0x3FF, read 0x400=0x000003FF.
  - Write 0x5 to 0x800 → no state change, read 0x800 → 0.
  - Write to 0x404 → ignored.
- Switch sync: Switches 0→0x2A1 at edge N. Read 0x404 = 0 after edge N+1 and 0x2A1 after edge N+2.
- One-shot timer: TCMP=5, TCOUNT=0, TCTRL=0x9.
  - 5 edges later TCOUNT=5; next edge MATCH=1, EN=0, TimerIrq=1; TCOUNT stays 5.
  - Write TCTRL=0x4 → MATCH=0, TimerIrq=0, IE=0.
- Auto-reload and collision:
  - TCMP=2, TCTRL=0x3 → count sequence 0,1,2,0,1,2; MATCH set on the first wrap.
  - Issue a W1C on the exact cycle of the second match → MATCH remains 1.
  - A TCOUNT write of 0x100 during counting overrides the increment → next read 0x100.
- Wrap and reset: TCMP=0, TCOUNT=0xFFFF_FFFE, EN=1 → count goes 0xFFFF_FFFF, then 0, then MATCH.
  - Assert reset mid-count → TCOUNT=0, TCMP=0xFFFF_FFFF, Leds=0, TimerIrq=0 the next cycle.
